dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_seq_if.sv | 35 +++
 rtl/dsp_mac_seq.sv | 121 ++++++++++++
 tb/tb_dsp_mac_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_seq_if.sv
// Bundle of the dot-product request, operand, DSP-slice and result signals.
interface dsp_mac_seq_if #(
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned OP_W  = 18;
  localparam int unsigned P_W   = 48;
  localparam int unsigned OPM_W = 8;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [OP_W-1:0]  dsp_a;
  logic [OP_W-1:0]  dsp_b;
  logic [OPM_W-1:0] dsp_opmode;
  logic             dsp_ce;
  logic [P_W-1:0]   dsp_p;
  logic [P_W-1:0]   res_data;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, len, in_valid, in_a, in_b, dsp_p, res_ready,
    input  in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, res_data, res_valid, busy, done
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, dsp_p, res_ready,
    output in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, res_data, res_valid, busy, done
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequencer feeding an external pipelined DSP slice (A1/B1, M, P, OPMODE regs)
// to compute an unsigned dot product of LEN operand pairs.
module dsp_mac_seq #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned OP_DLY = 1,
  parameter int unsigned P_LAT  = 3
) (
  input logic          clk,
  input logic          rst,
  dsp_mac_seq_if.slave bus
);
  localparam int unsigned OPM_W = 8;
  localparam int unsigned TAG_W = 2;
  localparam int unsigned DRN_W = $clog2(P_LAT + 1);

  localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
  localparam logic [OPM_W-1:0] OPM_NEXT  = 8'h09;
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [DRN_W-1:0] drain_cnt;
  logic             first_pend;
  logic [TAG_W-1:0] tag_q [OP_DLY];
  logic             accept_c;

  assign accept_c = bus.in_valid && bus.in_ready;

  // Issue tag {valid, first} -> OPMODE; a bubble keeps P via Z=P, X=0.
  function automatic logic [OPM_W-1:0] opmode_of(input logic [TAG_W-1:0] tag);
    if (!tag[1]) return OPM_HOLD;
    if (tag[0])  return OPM_FIRST;
    return OPM_NEXT;
  endfunction

  // Tag for issue cycle k is tag_q[0]; OPMODE appears OP_DLY cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OP_DLY); i++) tag_q[i] <= '0;
      bus.dsp_opmode <= '0;
    end else begin
      tag_q[0] <= {accept_c, accept_c & first_pend};
      for (int i = 1; i < int'(OP_DLY); i++) tag_q[i] <= tag_q[i-1];
      bus.dsp_opmode <= opmode_of(tag_q[OP_DLY-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      drain_cnt     <= '0;
      first_pend    <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.dsp_ce    <= 1'b0;
      bus.dsp_a     <= '0;
      bus.dsp_b     <= '0;
      bus.res_data  <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept_c) begin
        bus.dsp_a <= bus.in_a;
        bus.dsp_b <= bus.in_b;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.len == '0) begin
              bus.res_data  <= '0;
              bus.res_valid <= 1'b1;
              state         <= OUT;
            end else begin
              remaining    <= bus.len;
              first_pend   <= 1'b1;
              bus.in_ready <= 1'b1;
              bus.dsp_ce   <= 1'b1;
              state        <= RUN;
            end
          end
        end
        RUN: begin
          if (accept_c) begin
            remaining  <= remaining - LEN_W'(1);
            first_pend <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              bus.in_ready <= 1'b0;
              drain_cnt    <= DRN_W'(P_LAT);
              state        <= DRAIN;
            end
          end
        end
        // Counts down to the cycle where the last pair's P sits on dsp_p.
        DRAIN: begin
          if (drain_cnt == '0) begin
            bus.res_data  <= bus.dsp_p;
            bus.res_valid <= 1'b1;
            bus.dsp_ce    <= 1'b0;
            state         <= OUT;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP slice
// (A1/B1 -> M -> P, registered OPMODE, common CE, no reset).
module tb_dsp_mac_seq;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned NVEC  = 7;

  typedef logic [3:0][17:0] pair4_t;
  typedef struct {
    int unsigned len;
    pair4_t      a;
    pair4_t      b;
    int unsigned gap;
    int unsigned hold;
    bit          poke;
    logic [47:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dsp_mac_seq_if #(.LEN_W(LEN_W)) bus ();

  dsp_mac_seq #(.LEN_W(LEN_W), .OP_DLY(1), .P_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // DSP slice model with stale power-up contents that the first pair must discard.
  logic [17:0] a1_r  = 18'h15A5A;
  logic [17:0] b1_r  = 18'h0BEEF;
  logic [35:0] m_r   = 36'hABCDE1234;
  logic [7:0]  opm_r = 8'h08;
  logic [47:0] p_r   = 48'hBAD0_BAD0_BAD0;

  always @(posedge clk) begin
    if (bus.dsp_ce) begin
      a1_r  <= bus.dsp_a;
      b1_r  <= bus.dsp_b;
      m_r   <= 36'(a1_r) * 36'(b1_r);
      opm_r <= bus.dsp_opmode;
      p_r   <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0) + ((opm_r[1:0] == 2'b01) ? 48'(m_r) : 48'd0);
    end
  end
  assign bus.dsp_p = p_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_opm(input logic [1:0] t);
    if (!t[1]) return 8'h08;
    return t[0] ? 8'h01 : 8'h09;
  endfunction

  function automatic vec_t mk(input int unsigned len, input pair4_t a, input pair4_t b,
                              input int unsigned gap, input int unsigned hold,
                              input bit poke, input logic [47:0] exp);
    vec_t v;
    v.len = len; v.a = a; v.b = b; v.gap = gap; v.hold = hold; v.poke = poke; v.exp = exp;
    return v;
  endfunction

  // Starts at a falling edge with the block idle; ends at a falling edge, idle again.
  task automatic run_vec(input vec_t v, input int idx);
    int   sent = 0;
    int   gapc = 0;
    int   lat = 0;
    bit   got = 0;
    bit   first = 1;
    logic will_acc = 1'b0;
    logic [1:0] t0 = 2'b00;
    logic [1:0] t1 = 2'b00;
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.start = 1'b1;
    bus.len   = LEN_W'(v.len);
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      t1 = t0;
      t0 = {will_acc, will_acc & first};
      if (will_acc) begin
        first = 0;
        sent++;
        lat = 1;
        gapc = int'(v.gap);
      end else if (lat > 0) begin
        lat++;
      end
      check({tag, " dsp_ce"}, 64'(bus.dsp_ce), 64'(!bus.res_valid));
      if (bus.dsp_ce) check({tag, " opmode"}, 64'(bus.dsp_opmode), 64'(exp_opm(t1)));
      if (bus.res_valid) begin
        got = 1;
        bus.in_valid = 1'b0;
        check({tag, " res_data"}, 64'(bus.res_data), 64'(v.exp));
        check({tag, " accepts"}, 64'(sent), 64'(v.len));
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        if (v.len == 0) check({tag, " len0 latency"}, 64'(cyc), 64'd0);
        else            check({tag, " latency"}, 64'(lat), 64'd5);
      end else begin
        if (gapc > 0) begin
          bus.in_valid = 1'b0;
          bus.in_a = 18'h2AAAA;
          bus.in_b = 18'h15555;
          gapc--;
        end else if (sent < int'(v.len)) begin
          bus.in_valid = 1'b1;
          bus.in_a = v.a[2'(sent % 4)];
          bus.in_b = v.b[2'(sent % 4)];
        end else begin
          bus.in_valid = 1'b0;
        end
        if (v.poke && cyc == 1) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'(1);
        end
      end
      will_acc = bus.in_valid && bus.in_ready;
    end
    if (!got) begin
      check({tag, " result timeout"}, 64'd0, 64'd1);
      return;
    end
    for (int h = 0; h < int'(v.hold); h++) begin
      bus.start = v.poke;
      bus.len   = '0;
      @(negedge clk);
      check({tag, " hold valid"}, 64'(bus.res_valid), 64'd1);
      check({tag, " hold data"}, 64'(bus.res_data), 64'(v.exp));
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " valid drop"}, 64'(bus.res_valid), 64'd0);
    check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " dsp_ce"}, 64'(bus.dsp_ce), 64'd0);
    check({tag, " dsp_a"}, 64'(bus.dsp_a), 64'd0);
    check({tag, " dsp_b"}, 64'(bus.dsp_b), 64'd0);
    check({tag, " dsp_opmode"}, 64'(bus.dsp_opmode), 64'd0);
    check({tag, " res_data"}, 64'(bus.res_data), 64'd0);
  endtask

  vec_t vecs [NVEC];
  logic [47:0] max_prod;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    // (2^18-1)^2 = 0xF_FFF8_0001
    max_prod = 48'(18'h3FFFF) * 48'(18'h3FFFF);
    vecs[0] = mk(3, {18'd0, 18'd6, 18'd4, 18'd2}, {18'd0, 18'd7, 18'd5, 18'd3}, 0, 0, 0, 48'h44);
    vecs[1] = mk(3, {18'd0, 18'd6, 18'd4, 18'd2}, {18'd0, 18'd7, 18'd5, 18'd3}, 2, 1, 0, 48'h44);
    vecs[2] = mk(2, {4{18'h3FFFF}}, {4{18'h3FFFF}}, 0, 0, 0, 48'h1F_FFF0_0002);
    vecs[3] = mk(0, '0, '0, 0, 4, 0, 48'h0);
    vecs[4] = mk(4, {18'd7, 18'd0, 18'h100, 18'd1}, {18'd9, 18'h3FFFF, 18'h200, 18'd1}, 1, 2, 0, 48'h20040);
    vecs[5] = mk(3, {18'd0, 18'd6, 18'd4, 18'd2}, {18'd0, 18'd7, 18'd5, 18'd3}, 0, 2, 1, 48'h44);
    vecs[6] = mk(255, {4{18'h3FFFF}}, {4{18'h3FFFF}}, 0, 0, 0, 48'd255 * max_prod);

    for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i], i);

    // Reset after one of three pairs, then a fresh single-pair run.
    bus.start = 1'b1;
    bus.len   = LEN_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 18'd2; bus.in_b = 18'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrun rst");
    run_vec(mk(1, {4{18'd5}}, {4{18'd5}}, 0, 0, 0, 48'h19), 7);

    // Reset while holding a result in OUT.
    bus.start = 1'b1;
    bus.len   = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("out rst pre valid", 64'(bus.res_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("out rst valid", 64'(bus.res_valid), 64'd0);
    check("out rst busy", 64'(bus.busy), 64'd0);
    run_vec(vecs[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
